// File: rtl/ecc_syndrome_decoder.sv
// ---------------------------------------------------------------------------
// ecc_syndrome_decoder
//
// Multi-cycle SECDED (extended Hamming) decoder. A codeword and width mode are
// captured on start. The syndrome and overall parity are registered one cycle
// later. Correction and info-bit extraction are registered one cycle after
// that, together with a one-cycle completion pulse.
//
// Codeword layout for width N (8/16/32):
//   c[N-1]   overall parity bit
//   c[p-1]   Hamming position p, p = 1..N-1 (powers of two are check bits)
//
// Ports:
//   clk             rising-edge clock
//   rst             asynchronous active-low reset
//   start           decode request, sampled only while idle
//   data_in         codeword (low N bits used)
//   mod             width mode: 0->8, 1->16, 2/3->32
//   busy            high while a decode is in flight
//   data_out        extracted info bits, LSB-first, zero-extended
//   num_of_errors   0, 1 or 2 (2 = uncorrectable)
//   operation_done  one-cycle result-valid pulse
//   err_pos         (only with ECC_DEC_ERR_POS_EN) corrected position, 0 when
//                   the overall-parity bit was hit or no single error occurred
//
// Optional feature macro: ECC_DEC_ERR_POS_EN
// ---------------------------------------------------------------------------
module ecc_syndrome_decoder #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            mod,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [1:0]            num_of_errors,
    output logic                  operation_done
`ifdef ECC_DEC_ERR_POS_EN
    ,
    output logic [5:0]            err_pos
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYND = 2'd1,
        ST_CORR = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_mod;
    logic [5:0]            r_synd;
    logic                  r_par;
    logic [5:0]            w_n;
    logic [1:0]            w_nerr;
    logic [DATA_WIDTH-1:0] w_flip;
    logic [DATA_WIDTH-1:0] w_info;

    // Codeword width in bits for a given mode; mode 3 aliases the 32-bit mode.
    function automatic logic [5:0] mod_width(input logic [1:0] m);
        logic [5:0] n;
        case (m)
            2'd0:    n = 6'd8;
            2'd1:    n = 6'd16;
            default: n = 6'd32;
        endcase
        return n;
    endfunction

    // XOR of every Hamming position p (1..n-1) whose codeword bit is set.
    function automatic logic [5:0] calc_synd(input logic [DATA_WIDTH-1:0] cw,
                                             input logic [5:0]            n);
        logic [5:0] s;
        s = 6'd0;
        for (int p = 1; p < 32; p++) begin
            if ((6'(p) < n) && cw[p-1]) begin
                s = s ^ 6'(p);
            end
        end
        return s;
    endfunction

    // Overall parity over the low n bits, the overall-parity bit included.
    function automatic logic calc_par(input logic [DATA_WIDTH-1:0] cw,
                                      input logic [5:0]            n);
        logic par;
        par = 1'b0;
        for (int p = 0; p < 32; p++) begin
            if (6'(p) < n) begin
                par = par ^ cw[p];
            end
        end
        return par;
    endfunction

    // Pack the non-power-of-two positions, ascending, into the low result bits.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] cw,
                                                      input logic [5:0]            n);
        logic [DATA_WIDTH-1:0] d;
        int                    k;
        d = '0;
        k = 0;
        for (int p = 1; p < 32; p++) begin
            if ((6'(p) < n) && ((p & (p - 1)) != 0)) begin
                d[k] = cw[p-1];
                k = k + 1;
            end
        end
        return d;
    endfunction

    assign w_n = mod_width(r_mod);

    // Next-state logic: one fixed pass IDLE->SYND->CORR->DONE->IDLE per start.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_SYND;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_SYND: w_state_next = ST_CORR;
            ST_CORR: w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Error classification and single-bit correction from the registered syndrome.
    always_comb begin
        w_nerr = 2'd0;
        w_flip = '0;
        if (r_par) begin
            w_nerr = 2'd1;
        end else if (r_synd != 6'd0) begin
            w_nerr = 2'd2;
        end else begin
            w_nerr = 2'd0;
        end
        // Syndrome 0 with odd parity means the overall-parity bit itself
        // flipped; it carries no info, so nothing to correct.
        if (r_par && (r_synd != 6'd0)) begin
            w_flip[r_synd - 6'd1] = 1'b1;
        end else begin
            w_flip = '0;
        end
    end

    assign w_info = extract(r_data ^ w_flip, w_n);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Capture the codeword and mode when a start is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_mod  <= 2'd0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_data <= data_in;
            r_mod  <= mod;
        end
    end

    // Register syndrome and overall parity of the captured codeword.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_synd <= 6'd0;
            r_par  <= 1'b0;
        end else if (r_state == ST_SYND) begin
            r_synd <= calc_synd(r_data, w_n);
            r_par  <= calc_par(r_data, w_n);
        end
    end

    // Result registers; they hold until the next decode completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out      <= '0;
            num_of_errors <= 2'd0;
        end else if (r_state == ST_CORR) begin
            data_out      <= w_info;
            num_of_errors <= w_nerr;
        end
    end

`ifdef ECC_DEC_ERR_POS_EN
    // Position of the corrected bit, reported only for single errors.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_pos <= 6'd0;
        end else if (r_state == ST_CORR) begin
            err_pos <= (w_nerr == 2'd1) ? r_synd : 6'd0;
        end
    end
`endif

    // Status flags, registered so they track the state register exactly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy           <= 1'b0;
            operation_done <= 1'b0;
        end else begin
            busy           <= (w_state_next != ST_IDLE);
            operation_done <= (r_state == ST_CORR);
        end
    end

endmodule

// File: tb/tb_ecc_syndrome_decoder.sv
module tb_ecc_syndrome_decoder;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [1:0]    mod = 2'd0;
    logic          busy;
    logic [DW-1:0] data_out;
    logic [1:0]    num_of_errors;
    logic          operation_done;
`ifdef ECC_DEC_ERR_POS_EN
    logic [5:0]    err_pos;
`endif

    ecc_syndrome_decoder #(.DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .data_in        (data_in),
        .mod            (mod),
        .busy           (busy),
        .data_out       (data_out),
        .num_of_errors  (num_of_errors),
        .operation_done (operation_done)
`ifdef ECC_DEC_ERR_POS_EN
        ,
        .err_pos        (err_pos)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  nerr;
        logic [5:0]  pos;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   pulses = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int width_of(input logic [1:0] m);
        if (m == 2'd0) return 8;
        if (m == 2'd1) return 16;
        return 32;
    endfunction

    // Reference decoder: syndrome as XOR of set positions, parity by popcount.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [1:0] m);
        exp_t        e;
        int          n;
        int          s;
        int          k;
        logic [31:0] cw;
        logic [63:0] mask;
        n    = width_of(m);
        mask = (64'd1 << n) - 64'd1;
        cw   = w & mask[31:0];
        s    = 0;
        for (int p = 1; p < n; p++) if (cw[p-1]) s = s ^ p;
        if ($countones(cw) % 2 == 1) e.nerr = 2'd1;
        else if (s != 0)             e.nerr = 2'd2;
        else                         e.nerr = 2'd0;
        if (e.nerr == 2'd1 && s != 0) cw[s-1] = ~cw[s-1];
        e.data = '0;
        k = 0;
        for (int p = 1; p < n; p++) begin
            if ($countones(p) != 1) begin
                e.data[k] = cw[p-1];
                k++;
            end
        end
        e.pos = (e.nerr == 2'd1) ? 6'(s) : 6'd0;
        e.cyc = 0;
        return e;
    endfunction

    // Build a valid codeword of width n carrying the given info bits.
    function automatic logic [31:0] encode(input logic [31:0] info, input int n);
        logic [31:0] cw;
        int          k;
        int          s;
        cw = '0;
        k  = 0;
        s  = 0;
        for (int p = 1; p < n; p++) begin
            if ($countones(p) != 1) begin
                cw[p-1] = info[k];
                k++;
            end
        end
        for (int p = 1; p < n; p++) if (cw[p-1]) s = s ^ p;
        for (int j = 0; (1 << j) < n; j++) if (((s >> j) & 1) == 1) cw[(1 << j) - 1] = 1'b1;
        cw[n-1] = ^cw;
        return cw;
    endfunction

    // Scoreboard monitor: compare each completion against the queued expectation.
    always @(negedge clk) begin
        if (operation_done === 1'b1) begin
            pulses++;
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got operation_done=1 expected no pending word (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("data_out", 64'(data_out), 64'(e.data));
                chk("num_of_errors", 64'(num_of_errors), 64'(e.nerr));
                chk("done_cycle", 64'(cyc), 64'(e.cyc + 2));
`ifdef ECC_DEC_ERR_POS_EN
                chk("err_pos", 64'(err_pos), 64'(e.pos));
`endif
            end
        end
    end

    // One decode: start for one cycle, scramble inputs mid-flight, check busy/done timing.
    task automatic run_op(input logic [31:0] d, input logic [1:0] m);
        exp_t e;
        @(negedge clk);
        start   = 1'b1;
        data_in = d;
        mod     = m;
        @(posedge clk);
        #1;
        e     = ref_decode(d, m);
        e.cyc = cyc;
        q.push_back(e);
        chk("busy_T", 64'(busy), 64'd1);
        @(negedge clk);
        start   = 1'b0;
        data_in = $urandom;
        mod     = 2'($urandom_range(0, 3));
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("busy_seq", 64'(busy), (i < 3) ? 64'd1 : 64'd0);
            chk("done_seq", 64'(operation_done), (i == 2) ? 64'd1 : 64'd0);
        end
    endtask

    logic [31:0] dir_d    [5] = '{32'h0000_0087, 32'h0000_0004, 32'h0000_0006, 32'hFFFF_0000, 32'h8000_0000};
    logic [1:0]  dir_m    [5] = '{2'd0, 2'd2, 2'd2, 2'd1, 2'd3};
    logic [31:0] dir_data [5] = '{32'd1, 32'd0, 32'd1, 32'd0, 32'd0};
    logic [1:0]  dir_nerr [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [5:0]  dir_pos  [5] = '{6'd0, 6'd3, 6'd0, 6'd0, 6'd0};

    initial begin
        int p0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_data_out", 64'(data_out), 64'd0);
        chk("rst_nerr", 64'(num_of_errors), 64'd0);
        chk("rst_done", 64'(operation_done), 64'd0);
`ifdef ECC_DEC_ERR_POS_EN
        chk("rst_err_pos", 64'(err_pos), 64'd0);
`endif
        @(negedge clk);
        rst = 1'b1;

        // Directed vectors with hand-derived results.
        for (int i = 0; i < 5; i++) begin
            run_op(dir_d[i], dir_m[i]);
            chk("dir_data", 64'(data_out), 64'(dir_data[i]));
            chk("dir_nerr", 64'(num_of_errors), 64'(dir_nerr[i]));
`ifdef ECC_DEC_ERR_POS_EN
            chk("dir_pos", 64'(err_pos), 64'(dir_pos[i]));
`endif
        end

        // Random encoded words with 0..2 flipped bits and junk above width.
        for (int i = 0; i < 60; i++) begin
            logic [1:0]  m;
            int          n;
            int          k;
            int          a;
            int          b;
            logic [31:0] cw;
            logic [63:0] mask;
            m    = 2'($urandom_range(0, 3));
            n    = width_of(m);
            cw   = encode($urandom, n);
            k    = $urandom_range(0, 2);
            a    = $urandom_range(0, n - 1);
            b    = (a + $urandom_range(1, n - 1)) % n;
            if (k >= 1) cw[a] = ~cw[a];
            if (k == 2) cw[b] = ~cw[b];
            mask = (64'd1 << n) - 64'd1;
            cw   = cw | (32'($urandom) & ~mask[31:0]);
            run_op(cw, m);
        end

        // Start held high for 12 cycles: accepted every 4th edge only.
        p0 = pulses;
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            data_in = $urandom;
            mod     = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            if (i % 4 == 0) begin
                e     = ref_decode(data_in, mod);
                e.cyc = cyc;
                q.push_back(e);
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("held_start_pulses", 64'(pulses - p0), 64'd3);

        // Make outputs nonzero, then abort a decode with reset at T+1.
        run_op(32'h0000_0087, 2'd0);
        @(negedge clk);
        start   = 1'b1;
        data_in = 32'h0000_0004;
        mod     = 2'd2;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_data_out", 64'(data_out), 64'd0);
        chk("abort_nerr", 64'(num_of_errors), 64'd0);
        chk("abort_done", 64'(operation_done), 64'd0);
`ifdef ECC_DEC_ERR_POS_EN
        chk("abort_err_pos", 64'(err_pos), 64'd0);
`endif
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_op(32'h0000_0006, 2'd2);
        chk("post_abort_nerr", 64'(num_of_errors), 64'd2);

        repeat (4) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ecc_syndrome_decoder.md
# ecc_syndrome_decoder

Multi-cycle SECDED (extended Hamming) decoder for the ECC block. It sits directly downstream of the APB register bank, which supplies a captured codeword, a codeword-width mode and a start strobe. It produces corrected information bits, an error count and a one-cycle completion pulse for the top-level `data_out` / `num_of_errors` / `operation_done` outputs.

## Interface
- `DATA_WIDTH`, 32, width of `data_in` and `data_out`; maximum codeword width; must be ≥ 32.
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — asynchronous, active-low reset.
- `start` input 1 — request to decode; sampled only in IDLE.
- `data_in` input DATA_WIDTH — codeword; only the low N bits are used.
- `mod` input 2 — codeword width: 0 → N=8, 1 → N=16, 2 → N=32, 3 → treated as 2.
- `busy` output 1 — high whenever state ≠ IDLE.
- `data_out` output DATA_WIDTH — extracted info bits, LSB-first, zero-extended.
- `num_of_errors` output 2 — 0, 1 or 2 (2 means "uncorrectable"); 3 is never driven.
- `operation_done` output 1 — single-cycle result-valid pulse.

## Operation
- Codeword layout:
  - `c[N-1]` is the overall parity bit.
  - `c[N-2:0]` hold Hamming positions p = 1..N-1, with position p at bit `c[p-1]`.
  - Positions that are powers of two are check bits; all others are info bits.
  - Info widths: 4, 11 and 26 bits for N = 8, 16, 32.
- Syndrome `s` = XOR of every p in 1..N-1 for which `c[p-1]` = 1. Width is log2(N) bits.
- `P` = XOR of all N bits.
- Classification:
  - s=0 and P=0: 0 errors.
  - P=1: 1 error. Flip position s; s=0 means the error is in `c[N-1]`, which does not affect the info bits.
  - s≠0 and P=0: 2 errors. No correction; info is extracted from the raw codeword.
- Extraction: take the info positions in ascending p order into `data_out[0]`, `data_out[1]`, and so on. All higher bits are 0.
- `data_in` bits at index N and above are ignored.
- FSM:
  - IDLE → SYND when `start`=1. `data_in` and `mod` are captured at this edge.
  - SYND → CORR: the registered `s` and `P` are computed.
  - CORR → DONE: correction and extraction are done; `data_out` and `num_of_errors` are registered.
  - DONE → IDLE.
- `start` is ignored in SYND, CORR and DONE. No queuing.
- `data_out` and `num_of_errors` hold their value until the next result is registered.
- Changes to `data_in` or `mod` after capture have no effect on the operation in flight.

## Timing
- Reset values:
  - state = IDLE.
  - `busy` = 0, `data_out` = 0, `num_of_errors` = 0, `operation_done` = 0.
  - Internal capture, syndrome and parity registers = 0.
- Let T be the edge at which `start` is sampled high in IDLE.
- `busy`:
  - high after edges T, T+1 and T+2;
  - low after edge T+3.
- Results:
  - `data_out` and `num_of_errors` are updated at edge T+2.
  - `operation_done` is 1 for exactly the cycle between edges T+2 and T+3.
- Minimum start-to-start spacing is 4 cycles. A `start` held high continuously is accepted at T, T+4, T+8, …
- Reset asserted mid-operation: the FSM returns to IDLE immediately and all outputs clear. No `operation_done` is produced for the aborted word.
- Reset released: the first `start` can be sampled on the first rising edge with `rst`=1.

## Configuration
- `ECC_DEC_ERR_POS_EN` defined:
  - Adds output `err_pos` (6 bits).
  - It is registered at edge T+2 alongside `data_out`.
  - Value is s when `num_of_errors`=1 (with 0 meaning the overall-parity bit); otherwise 0.
  - Reset value is 0.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `mod`=0, `data_in`=32'h0000_0087, `start` pulse → at T+2: `data_out`=1, `num_of_errors`=0, `operation_done` high one cycle, `busy` high for exactly 3 cycles.
- `mod`=2, `data_in`=32'h0000_0004 (position 3 flipped in the zero codeword) → `data_out`=0, `num_of_errors`=1, `err_pos`=3 if the macro is enabled.
- `mod`=2, `data_in`=32'h0000_0006 (positions 2 and 3 flipped) → `num_of_errors`=2, `data_out`=1 (raw info bit at position 3), `err_pos`=0.
- `mod`=1, `data_in`=32'hFFFF_0000 → bits above 15 ignored, so `data_out`=0, `num_of_errors`=0. Also `mod`=3 with `data_in`=32'h8000_0000 → `num_of_errors`=1, `data_out`=0 (behaves as `mod`=2).
- `start` held high for 12 cycles with `data_in` changing every cycle → exactly 3 `operation_done` pulses, at T+2, T+6 and T+10, each matching the `data_in` captured at T, T+4 and T+8.
- Reset asserted at T+1 → outputs 0 immediately, no `operation_done`. After release, a new `start` decodes normally.
